// File: rtl/bias_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bias_pkg : shared widths, saturation limits and lane helpers         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bias_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_N_LANES = 16;
  localparam int DEF_N_GROUPS = 8;

  localparam int SAT_MAX = (2 ** (DEF_DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_DATA_W - 1));

  // One extra bit so the raw sum of two DATA_W operands never wraps
  typedef logic signed [DEF_DATA_W:0] sum_t;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bias_sat_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bias_sat_lane : add bias to one lane, saturate, optional ReLU         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bias_sat_lane
  import bias_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic signed [DATA_W-1:0] i_data,
  input  logic signed [DATA_W-1:0] i_bias,
  input  logic                     i_relu,
  output logic signed [DATA_W-1:0] o_res
);

  localparam logic signed [DATA_W:0] c_SAT_MAX = (DATA_W+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W:0] c_SAT_MIN = (DATA_W+1)'(-(2 ** (DATA_W - 1)));

  logic signed [DATA_W:0]   w_sum;
  logic signed [DATA_W-1:0] w_sat;

  assign w_sum = {i_data[DATA_W-1], i_data} + {i_bias[DATA_W-1], i_bias};

  always_comb begin
    w_sat = w_sum[DATA_W-1:0];
    if (w_sum > c_SAT_MAX) begin
      w_sat = c_SAT_MAX[DATA_W-1:0];
    end else if (w_sum < c_SAT_MIN) begin
      w_sat = c_SAT_MIN[DATA_W-1:0];
    end
  end

  assign o_res = (i_relu && w_sat[DATA_W-1]) ? '0 : w_sat;

endmodule
`default_nettype wire

// File: rtl/bias_bank_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bias_bank_add : loadable per-channel bias bank applied to each        |
// | adder-tree beat, with saturation and optional ReLU.  Rev 1.0          |
// +----------------------------------------------------------------------+
module bias_bank_add
  import bias_pkg::*;
#(
  parameter  int N_adder_tree = DEF_N_LANES,
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int N_GROUPS     = DEF_N_GROUPS,
  parameter  int ADDR_W       = $clog2(N_GROUPS * N_adder_tree),
  localparam int GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_relu,
  input  logic                           bias_we,
  input  logic [ADDR_W-1:0]              bias_waddr,
  input  logic [DATA_W-1:0]              bias_wdata,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic [GRP_W-1:0]               out_group,
  output logic                           out_last
);

  localparam int                 c_N_CH     = N_GROUPS * N_adder_tree;
  localparam logic [ADDR_W:0]    c_N_CH_LIM = (ADDR_W+1)'(c_N_CH);
  localparam logic [GRP_W-1:0]   c_GRP_MAX  = GRP_W'(N_GROUPS - 1);

  logic [DATA_W-1:0]              r_bias [c_N_CH];
  logic [GRP_W-1:0]               r_grp;
  logic                           r_out_valid;
  logic [N_adder_tree*DATA_W-1:0] r_out_data;
  logic [GRP_W-1:0]               r_out_group;
  logic                           r_out_last;

  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_wr_ok;
  logic [GRP_W-1:0]               w_grp_nxt;
  logic [N_adder_tree*DATA_W-1:0] w_res;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_wr_ok    = bias_we && ({1'b0, bias_waddr} < c_N_CH_LIM);

  always_comb begin
    w_grp_nxt = r_grp + GRP_W'(1);
    if (in_last || (r_grp == c_GRP_MAX)) begin
      w_grp_nxt = '0;
    end
  end

  // Reads see the pre-edge array, so a same-cycle write to the beat's own channel uses the old bias
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_N_CH; k++) begin
        r_bias[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_bias[bias_waddr] <= bias_wdata;
    end
  end

  generate
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      localparam int c_LO = lane_lo(i, DATA_W);
      logic [ADDR_W-1:0] w_idx;
      logic [DATA_W-1:0] w_lane_res;

      assign w_idx = ADDR_W'(r_grp) * ADDR_W'(N_adder_tree) + ADDR_W'(i);

      bias_sat_lane #(
        .DATA_W (DATA_W)
      ) u_lane (
        .i_data (in_data[c_LO +: DATA_W]),
        .i_bias (r_bias[w_idx]),
        .i_relu (cfg_relu),
        .o_res  (w_lane_res)
      );

      assign w_res[c_LO +: DATA_W] = w_lane_res;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grp       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_group <= '0;
      r_out_last  <= 1'b0;
    end else if (w_in_ready) begin
      r_out_valid <= in_valid;
      if (w_accept) begin
        r_out_data  <= w_res;
        r_out_group <= r_grp;
        r_out_last  <= in_last;
        r_grp       <= w_grp_nxt;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_group = r_out_group;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/bias_bank_add.md
Name: bias_bank_add

Overview:
- Parametrised successor to the per-layer hard-wired bias constant banks.
- Holds a loadable bias memory for N_GROUPS × N_adder_tree output channels.
- Adds the selected group's biases to each adder-tree output beat, saturates, and optionally applies ReLU.
- Sits between the adder tree and the layer output buffer. One instance serves any layer; no per-layer constant modules are needed.

Parameters:
- N_adder_tree, 16, lanes per beat (channels per group).
- DATA_W, 18, signed fixed-point width of data, bias and result.
- N_GROUPS, 8, channel groups stored; channel = group*N_adder_tree + lane.
- ADDR_W, $clog2(N_GROUPS*N_adder_tree), bias write address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cfg_relu  in  1  1 = clamp negative results to 0; sampled per accepted beat.
- bias_we  in  1  bias write strobe.
- bias_waddr  in  ADDR_W  channel index written.
- bias_wdata  in  DATA_W  signed bias value.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  N_adder_tree*DATA_W  lane i at [DATA_W*(i+1)-1 : DATA_W*i].
- in_last  in  1  last beat of tile; group pointer returns to 0 after it.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  N_adder_tree*DATA_W  biased, saturated lanes, same packing as in_data.
- out_group  out  $clog2(N_GROUPS)  group index used for this beat.
- out_last  out  1  in_last carried with the beat.

Behaviour:
- Reset (async, rst=1) clears:
  - all bias entries to 0;
  - group pointer to 0;
  - out_valid, out_data, out_group and out_last to 0.
  - Reset mid-stream discards the held beat. Biases must be reloaded after reset.
- Handshake and latency:
  - in_ready = !out_valid | out_ready (single output register, no combinational path from in_valid to out_valid).
  - Latency is 1 cycle from acceptance to out_valid.
  - Full throughput is one beat per cycle while out_ready=1.
  - out_* hold stable while out_valid & !out_ready.
- Group pointer:
  - Advances by 1 on every accepted beat; wraps N_GROUPS-1 -> 0.
  - If in_last is set on an accepted beat, the next pointer is 0 regardless of position.
  - out_group equals the pointer value at acceptance.
- Arithmetic, per lane:
  - sum = sext(in) + sext(bias), computed at DATA_W+1 bits.
  - If sum > 2^(DATA_W-1)-1, result = 2^(DATA_W-1)-1 (131071).
  - If sum < -2^(DATA_W-1), result = -2^(DATA_W-1) (-131072).
  - If cfg_relu=1 and the result is negative, result = 0.
- Bias writes:
  - Accepted any cycle, independent of streaming; the write lands at the clock edge.
  - A beat accepted in the same cycle as a write to its own channel uses the OLD bias.
  - bias_waddr >= N_GROUPS*N_adder_tree is ignored (no write).
- State: pointer FSM is implicit (counter). No other states.

Decomposition:
- Package bias_pkg holds:
  - DATA_W default;
  - SAT_MAX and SAT_MIN localparams;
  - lane slice helper function;
  - result type for the DATA_W+1 sum.
- Sub-module bias_sat_lane: combinational add, saturate and ReLU for one lane, instantiated N_adder_tree times by generate.
- Top level holds the bias register array, pointer and output register.

Test Plan:
- Load channel 0 = 18'h0095C (2396) and channel 1 = -104. Send a beat with lane0=100, lane1=50, cfg_relu=0. Expect lane0=2496, lane1=-54, out_group=0, one cycle later.
- Saturation: lane0 bias 1000 with in 131071 -> 131071. Lane1 bias -1000 with in -131072 -> -131072.
- ReLU: cfg_relu=1, in=-500, bias=100 -> 0. Same beat with cfg_relu=0 -> -400.
- Pointer: 10 consecutive beats with N_GROUPS=8 -> out_group 0..7,0,1. Then a beat with in_last=1 at group 2 -> next out_group=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1. Expect in_ready=0, out_data stable, no beat lost or duplicated. On release, beats emerge in order.
- Write collision and reset: write channel 16 (group 1 lane 0) = 7 in the same cycle a group-1 beat is accepted -> old bias used; the next group-1 beat uses 7. Assert rst while out_valid=1 -> out_valid=0 immediately, biases read back as 0 effect (in=5 -> out=5).
